// File: rtl/fb_scanout.sv
// VGA scan-out engine: generates raster timing, fetches one framebuffer word per
// displayed pixel (with integer upscaling) and drives registered RGB/sync pins.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 19
`endif

module fb_scanout #(
    parameter int CLK_DIV     = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic [`DISP_ADDR_WIDTH-1:0] fb_raddr,
    input  logic [31:0]                 fb_rdata,
    output logic [3:0]                  vga_r,
    output logic [3:0]                  vga_g,
    output logic [3:0]                  vga_b,
    output logic                        vga_hs,
    output logic                        vga_vs,
    output logic                        frame_start
);

    localparam int AW      = `DISP_ADDR_WIDTH;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ZERO   = DW'(0);
    localparam logic [DW-1:0] D_ONE      = DW'(1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [HW-1:0] H_VIS_C    = HW'(H_VIS);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ONE      = VW'(1);
    localparam logic [VW-1:0] V_VIS_C    = VW'(V_VIS);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VIS - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [AW-1:0] FB_W       = AW'(H_VIS >> SCALE_SHIFT);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW-1:0] fb_raddr_q, fb_raddr_d;
    logic          active_q, active_d;
    logic          hs_cond_q, hs_cond_d;
    logic          vs_cond_q, vs_cond_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          vga_hs_q, vga_hs_d;
    logic          vga_vs_q, vga_vs_d;
    logic          frame_start_q, frame_start_d;

    logic          pix_en_s;
    logic          fetch_en_s;
    logic          active_s;
    logic          hs_cond_s;
    logic          vs_cond_s;
    logic [AW-1:0] row_s;
    logic [AW-1:0] col_s;
    logic [AW-1:0] addr_s;
    logic          unused_rdata_s;

    // Fetch runs on the clock after each pixel strobe, i.e. when the divider is back at zero.
    assign pix_en_s       = (div_cnt_q == DIV_LAST);
    assign fetch_en_s     = (div_cnt_q == DIV_ZERO);
    assign unused_rdata_s = ^fb_rdata[31:12];

    // Pixel divider and raster counters.
    always_comb begin
        div_cnt_d = div_cnt_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en_s) begin
            div_cnt_d = DIV_ZERO;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + V_ONE;
                end
            end else begin
                h_cnt_d = h_cnt_q + H_ONE;
            end
        end else begin
            div_cnt_d = div_cnt_q + D_ONE;
        end
    end

    // Raster position decode and framebuffer address for the current pixel.
    always_comb begin
        active_s  = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        hs_cond_s = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
        vs_cond_s = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
        row_s     = AW'(v_cnt_q >> SCALE_SHIFT);
        col_s     = AW'(h_cnt_q >> SCALE_SHIFT);
        addr_s    = row_s * FB_W + col_s;
    end

    // Stage 0: issue the RAM read and capture blank/sync flags alongside it.
    always_comb begin
        fb_raddr_d = fb_raddr_q;
        active_d   = active_q;
        hs_cond_d  = hs_cond_q;
        vs_cond_d  = vs_cond_q;
        if (fetch_en_s) begin
            active_d  = active_s;
            hs_cond_d = hs_cond_s;
            vs_cond_d = vs_cond_s;
            if (active_s) begin
                fb_raddr_d = addr_s;
            end else begin
                fb_raddr_d = fb_raddr_q;
            end
        end else begin
            fb_raddr_d = fb_raddr_q;
        end
    end

    // Stage 2: drive the pins on the next pixel strobe; frame pulse marks vblank entry.
    always_comb begin
        rgb_d         = rgb_q;
        vga_hs_d      = vga_hs_q;
        vga_vs_d      = vga_vs_q;
        frame_start_d = pix_en_s && (h_cnt_q == H_LAST) && (v_cnt_q == V_VIS_LAST);
        if (pix_en_s) begin
            rgb_d    = active_q ? fb_rdata[11:0] : 12'h000;
            vga_hs_d = ~hs_cond_q;
            vga_vs_d = ~vs_cond_q;
        end else begin
            rgb_d    = rgb_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            fb_raddr_q    <= '0;
            active_q      <= 1'b0;
            hs_cond_q     <= 1'b0;
            vs_cond_q     <= 1'b0;
            rgb_q         <= 12'h000;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            fb_raddr_q    <= fb_raddr_d;
            active_q      <= active_d;
            hs_cond_q     <= hs_cond_d;
            vs_cond_q     <= vs_cond_d;
            rgb_q         <= rgb_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fb_raddr    = fb_raddr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: two instances (2x upscale and 1x) on a shrunken raster,
// checked every clock against a pixel-index model of the expected pin values.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 19
`endif

module tb_fb_scanout;

    localparam int AW    = `DISP_ADDR_WIDTH;
    localparam int CD    = 4;
    localparam int HV    = 16;
    localparam int HF    = 2;
    localparam int HS    = 3;
    localparam int HB    = 2;
    localparam int VV    = 8;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int MAX1  = (HV / 2) * (VV / 2) - 1;
    localparam int MAX0  = HV * VV - 1;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] raddr1, raddr0;
    logic [31:0]   rdata1, rdata0;
    logic [3:0]    r1, g1, b1, r0, g0, b0;
    logic          hs1, vs1, fs1, hs0, vs0, fs0;

    int  mode;
    int  salt;
    int  k;
    bit  armed;
    int  n_cmp;
    int  n_err;

    fb_scanout #(.CLK_DIV(CD), .SCALE_SHIFT(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .fb_raddr(raddr1), .fb_rdata(rdata1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1), .frame_start(fs1)
    );

    fb_scanout #(.CLK_DIV(CD), .SCALE_SHIFT(0), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .fb_raddr(raddr0), .fb_rdata(rdata0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0), .frame_start(fs0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Colour content of framebuffer word a, depending on the current test mode.
    function automatic logic [11:0] lo12(input int a, input int md, input int s);
        int h;
        case (md)
            0:       h = a;
            1:       h = 32'hFFF;
            default: h = a * 131 + s;
        endcase
        return h[11:0];
    endfunction

    function automatic int addr_of(input int x, input int y, input int sh);
        return (y >> sh) * (HV >> sh) + (x >> sh);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // Synchronous-read RAM models: one clock of latency, upper bits are noise.
    always @(posedge clk) begin
        rdata1 <= {(mode == 0) ? 20'hFFFFF : 20'($urandom()), lo12(int'(raddr1), mode, salt)};
        rdata0 <= {(mode == 0) ? 20'hFFFFF : 20'($urandom()), lo12(int'(raddr0), mode, salt)};
    end

    // k = number of clock edges since reset was last released (0 while in reset).
    always @(posedge clk) begin
        if (!reset_n) begin
            k     <= 0;
            armed <= 1'b1;
        end else begin
            k     <= k + 1;
        end
    end

    int          m, n, x, y, p;
    bit          vis;
    int          exp_ra1, exp_ra0;
    logic [11:0] e_rgb1, e_rgb0;
    logic        e_hs, e_vs, e_fs;
    logic        hs_prev, vs_prev, fs_prev;
    bit          hs_seen, vs_seen, fs_seen;
    int          hs_fall, vs_fall, fs_rise;

    // Compare process: every clock, derive expected pins from the pixel index.
    always @(negedge clk) begin
        if (armed) begin
            if (k == 0) begin
                exp_ra1 = 0;
                exp_ra0 = 0;
            end else if ((k - 1) % CD == 0) begin
                m = (k - 1) / CD;
                n = m % FRAME;
                x = n % HT;
                y = n / HT;
                if (x < HV && y < VV) begin
                    exp_ra1 = addr_of(x, y, 1);
                    exp_ra0 = addr_of(x, y, 0);
                end
            end
            if (k < CD) begin
                e_rgb1 = 12'h000;
                e_rgb0 = 12'h000;
                e_hs   = 1'b1;
                e_vs   = 1'b1;
            end else begin
                p   = k / CD - 1;
                n   = p % FRAME;
                x   = n % HT;
                y   = n / HT;
                vis = (x < HV) && (y < VV);
                e_rgb1 = vis ? lo12(addr_of(x, y, 1), mode, salt) : 12'h000;
                e_rgb0 = vis ? lo12(addr_of(x, y, 0), mode, salt) : 12'h000;
                e_hs   = !(x >= HV + HF && x < HV + HF + HS);
                e_vs   = !(y >= VV + VF && y < VV + VF + VS);
            end
            e_fs = (k > 0) && (k % CD == 0) && ((k / CD) % FRAME == VV * HT);

            chk("raddr1", 32'(raddr1), exp_ra1);
            chk("rgb1", {20'd0, r1, g1, b1}, {20'd0, e_rgb1});
            chk("hs1", {31'd0, hs1}, {31'd0, e_hs});
            chk("vs1", {31'd0, vs1}, {31'd0, e_vs});
            chk("fs1", {31'd0, fs1}, {31'd0, e_fs});
            chk("raddr1_range", (int'(raddr1) <= MAX1) ? 1 : 0, 1);
            chk("raddr0", 32'(raddr0), exp_ra0);
            chk("rgb0", {20'd0, r0, g0, b0}, {20'd0, e_rgb0});
            chk("hs0", {31'd0, hs0}, {31'd0, e_hs});
            chk("vs0", {31'd0, vs0}, {31'd0, e_vs});
            chk("fs0", {31'd0, fs0}, {31'd0, e_fs});
            chk("raddr0_range", (int'(raddr0) <= MAX0) ? 1 : 0, 1);

            // Hand-computed anchors: pixel (3,5) and the last visible pixel (15,7).
            if (k == (5 * HT + 3) * CD + 1) begin
                chk("lit_raddr1_3_5", 32'(raddr1), 32'd17);
                chk("lit_raddr0_3_5", 32'(raddr0), 32'd83);
            end
            if (k == (5 * HT + 4) * CD + 1 && mode == 0) begin
                chk("lit_rgb1_3_5", {20'd0, r1, g1, b1}, 32'h011);
                chk("lit_rgb0_3_5", {20'd0, r0, g0, b0}, 32'h053);
            end
            if (k == (7 * HT + 15) * CD + 1) begin
                chk("lit_raddr1_max", 32'(raddr1), 32'd31);
                chk("lit_raddr0_max", 32'(raddr0), 32'd127);
            end
            if (k == (7 * HT + 16) * CD + 1 && mode == 0) begin
                chk("lit_rgb1_max", {20'd0, r1, g1, b1}, 32'h01F);
                chk("lit_rgb0_max", {20'd0, r0, g0, b0}, 32'h07F);
            end

            // Sync and frame-pulse edge timing measured in clocks since release.
            if (k == 0) begin
                hs_seen = 1'b0;
                vs_seen = 1'b0;
                fs_seen = 1'b0;
            end else begin
                if (hs_prev && !hs1) begin
                    if (!hs_seen) chk("hs_first_fall", k, (HV + HF + 1) * CD);
                    else          chk("hs_period", k - hs_fall, HT * CD);
                    hs_seen = 1'b1;
                    hs_fall = k;
                end else if (!hs_prev && hs1 && hs_seen) begin
                    chk("hs_low_len", k - hs_fall, HS * CD);
                end
                if (vs_prev && !vs1) begin
                    if (!vs_seen) chk("vs_first_fall", k, ((VV + VF) * HT + 1) * CD);
                    else          chk("vs_period", k - vs_fall, FRAME * CD);
                    vs_seen = 1'b1;
                    vs_fall = k;
                end else if (!vs_prev && vs1 && vs_seen) begin
                    chk("vs_low_len", k - vs_fall, VS * HT * CD);
                end
                if (!fs_prev && fs1) begin
                    if (!fs_seen) chk("fs_first", k, VV * HT * CD);
                    else          chk("fs_period", k - fs_rise, FRAME * CD);
                    fs_seen = 1'b1;
                    fs_rise = k;
                end else if (fs_prev && !fs1 && fs_seen) begin
                    chk("fs_width", k - fs_rise, 1);
                end
            end
            hs_prev = hs1;
            vs_prev = vs1;
            fs_prev = fs1;
        end
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        k       = 0;
        armed   = 1'b0;
        mode    = 0;
        salt    = 0;
        hs_prev = 1'b1;
        vs_prev = 1'b1;
        fs_prev = 1'b0;
        reset_n = 1'b0;

        // Reset hold, then more than two frames of address-pattern data.
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (3 * FRAME * CD - 400) @(negedge clk);

        // Constant white with random upper bits: blanking check.
        reset_n = 1'b0;
        @(negedge clk);
        mode = 1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (FRAME * CD + 300) @(negedge clk);

        // Random content, interrupted by a one-clock reset at v=5, h=10.
        reset_n = 1'b0;
        @(negedge clk);
        mode = 2;
        salt = int'($urandom_range(0, 4095));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat ((5 * HT + 10) * CD + 2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (FRAME * CD + 200) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Read-side counterpart to the screen modules that write the display framebuffer. They write through fb_we/fb_addr/fb_wdata; this block reads the same RAM continuously and drives the VGA pins.
- Generates 640x480@60 timing and fetches one framebuffer word per displayed pixel, with integer upscaling.
- Outputs 12-bit RGB, HS/VS, and a frame-boundary pulse that the screen FSMs use for tear-free updates.

Parameters:
- CLK_DIV, 4, system clocks per pixel; must be >= 3 so RAM data returns before the next pixel.
- SCALE_SHIFT, 1, log2 of the upscale factor. Framebuffer is (640>>SCALE_SHIFT) x (480>>SCALE_SHIFT) words.
- H_VIS, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_VIS, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- fb_raddr  out  `DISP_ADDR_WIDTH  framebuffer read address; the RAM returns data 1 clk later.
- fb_rdata  in  32  framebuffer read data; colour is in bits [11:0] as {R[11:8],G[7:4],B[3:0]}, bits [31:12] are ignored.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- frame_start  out  1  one-clk pulse when the last visible line has been fetched (start of vblank).

Behaviour:
- Reset (reset_n low at a clk edge):
  - div_cnt, h_cnt, v_cnt, fb_raddr and all RGB outputs go to 0.
  - vga_hs and vga_vs go to 1; frame_start goes to 0.
  - Applies mid-line or mid-frame with no partial-frame completion; the next frame starts at h=0, v=0.
- Pixel enable: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en=1 on the clk where div_cnt==CLK_DIV-1, which gives exactly one pixel every CLK_DIV clocks.
- Counters, advanced on pix_en only:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL=800) and wraps.
  - At the h_cnt wrap, v_cnt increments and runs 0..V_TOTAL-1 (V_TOTAL=525), wrapping to 0.
- Stage 0, on the clk after pix_en, using the new counter values:
  - active = (h_cnt<H_VIS)&&(v_cnt<V_VIS).
  - fb_raddr <= (v_cnt>>SCALE_SHIFT)*(H_VIS>>SCALE_SHIFT) + (h_cnt>>SCALE_SHIFT) when active.
  - fb_raddr holds its previous value when not active; no out-of-range address is ever issued.
  - Multiply width is DISP_ADDR_WIDTH; the maximum address is (FB_W*FB_H)-1, which is 76799 at defaults.
- Stage 1 (RAM): fb_rdata is valid 1 clk after fb_raddr changes.
- Stage 2, on the next pix_en:
  - {vga_r,vga_g,vga_b} <= active_d ? fb_rdata[11:0] : 12'h000.
  - vga_hs <= ~(hs_cond_d) and vga_vs <= ~(vs_cond_d), where hs_cond = H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC and vs_cond uses the analogous vertical bounds.
  - active, hs_cond and vs_cond are registered alongside fb_raddr, so colour, sync and blank are mutually aligned.
- Latency: pins lag the counters by exactly one pixel period (CLK_DIV clocks).
- Blanking: RGB must be 0 during every non-active pixel, including the first pixel after reset.
- frame_start:
  - Asserted for exactly one clk, on the clk where h_cnt wraps from H_TOTAL-1 to 0 and v_cnt becomes V_VIS.
  - Never asserted more than once per frame; 1 pulse per 420000 pixels.
- Upscaling: with SCALE_SHIFT=1, each fetched word covers a 2x2 pixel block and consecutive pixels repeat the same address. The block issues the same address anyway, since RAM reads are free.
- fb_rdata bits [31:12] have no effect on any output.

Test Plan:
- Reset and timing:
  - Hold reset_n=0 for 10 clks.
  - Required: RGB=0, hs=vs=1, fb_raddr=0, frame_start=0.
  - Release reset and count clks.
  - Required: first vga_hs falling edge at clk (656+1)*4 ±1 pipeline, low for exactly 96*4=384 clks, period 3200 clks.
- Vertical timing:
  - Run 2 frames.
  - Required: vga_vs low for exactly 2 lines (6400 clks), period 525*3200=1680000 clks.
  - Required: frame_start pulses exactly once per period, each pulse 1 clk wide.
- Address mapping:
  - RAM model returns fb_rdata = {20'hFFFFF, addr[11:0]}.
  - Required at screen pixel (x=3,y=5): fb_raddr = 2*320+1 = 641; RGB = 12'h281.
  - Required: at pixel (639,479) fb_raddr = 76799, and no address > 76799 is ever issued.
- Blanking:
  - RAM returns 12'hFFF constantly.
  - Required: RGB=12'hFFF for all visible pixels and 0 for every pixel with h>=640 or v>=480.
  - Required: upper data bits are ignored.
- Reset mid-operation:
  - Assert reset_n=0 for 1 clk at v=200,h=300.
  - Required: outputs return to reset values on the next clk; the next frame_start occurs exactly 480 lines (+ pipeline) after release.
- Scale variant:
  - Set SCALE_SHIFT=0.
  - Required: fb_raddr = y*640+x, a new address every pixel, and a max address of 307199 (needs DISP_ADDR_WIDTH>=19).
